// File: rtl/matrix_column_scanner.sv
// ---------------------------------------------------------------------------
// matrix_column_scanner
//
// Purpose:
//   Time-multiplexing scan controller for a 5x7 LED status matrix. Once per
//   frame it takes a snapshot of the five column patterns and the display
//   state. It then drives one column at a time, in the order 4,3,2,1,0.
//   Each column slot is DWELL_CYCLES long and starts with BLANK_CYCLES of
//   all-off time to suppress ghosting. While the captured display state is
//   "error" (3'b010), the whole image blinks. Each half-period of the blink
//   is BLINK_FRAMES frames long.
//
// Ports:
//   clock          in   1  system clock, rising edge
//   reset_n        in   1  asynchronous active-low reset
//   enable         in   1  scan enable; low returns to idle and blanks
//   column_4..0    in   7  per-column LED pattern, 1 = lit
//   state          in   3  display state code, 3'b010 = error
//   column_enable  out  5  one-hot active-high column drive
//   row_n          out  7  active-low row drive
//   frame_done     out  1  pulse on the last cycle of every frame
//   scanning       out  1  high while the scan FSM is in SCAN
// ---------------------------------------------------------------------------
module matrix_column_scanner #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] column_4,
  input  logic [6:0] column_3,
  input  logic [6:0] column_2,
  input  logic [6:0] column_1,
  input  logic [6:0] column_0,
  input  logic [2:0] state,
  output logic [4:0] column_enable,
  output logic [6:0] row_n,
  output logic       frame_done,
  output logic       scanning
);

  localparam int TICK_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]  TICK_MAX   = TICK_W'(DWELL_CYCLES - 1);
  localparam logic [TICK_W-1:0]  TICK_BLANK = TICK_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [2:0] STATE_ERROR = 3'b010;
  localparam logic [2:0] COL_FIRST   = 3'd4;
  localparam logic [2:0] COL_LAST    = 3'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

  // Control state
  logic [1:0]         r_state;
  logic [TICK_W-1:0]  r_tick;
  logic [2:0]         r_column;

  // Frame snapshot
  logic [6:0]         r_snap4;
  logic [6:0]         r_snap3;
  logic [6:0]         r_snap2;
  logic [6:0]         r_snap1;
  logic [6:0]         r_snap0;
  logic [2:0]         r_snapState;

  // Blink tracking
  logic [BLINK_W-1:0] r_blinkCnt;
  logic               r_phaseOn;

  // Registered outputs
  logic [4:0]         r_columnEnable;
  logic [6:0]         r_rowN;
  logic               r_frameDone;
  logic               r_scanning;

  // Next-state values
  logic [1:0]         w_nextState;
  logic [TICK_W-1:0]  w_nextTick;
  logic [2:0]         w_nextColumn;
  logic               w_capture;
  logic               w_frameEnd;

  logic [6:0]         w_nextSnap4;
  logic [6:0]         w_nextSnap3;
  logic [6:0]         w_nextSnap2;
  logic [6:0]         w_nextSnap1;
  logic [6:0]         w_nextSnap0;
  logic [2:0]         w_nextSnapState;

  logic [BLINK_W-1:0] w_nextBlinkCnt;
  logic               w_nextPhaseOn;

  logic [6:0]         w_nextPattern;
  logic [4:0]         w_nextOneHot;
  logic               w_nextVisible;
  logic [4:0]         w_nextColumnEnable;
  logic [6:0]         w_nextRowN;
  logic               w_nextFrameDone;
  logic               w_nextScanning;

  // Scan sequencing. Dropping enable is honoured on any cycle, even in the
  // middle of a slot. The frame-end edge recaptures the inputs directly, with
  // no pass through LOAD, so that every frame is exactly 5*DWELL_CYCLES long.
  always_comb begin
    w_nextState  = r_state;
    w_nextTick   = r_tick;
    w_nextColumn = r_column;
    w_capture    = 1'b0;
    w_frameEnd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nextTick   = '0;
        w_nextColumn = COL_FIRST;
        if (enable) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        w_nextState  = S_SCAN;
        w_nextTick   = '0;
        w_nextColumn = COL_FIRST;
        w_capture    = 1'b1;
      end
      S_SCAN: begin
        if (!enable) begin
          w_nextState  = S_IDLE;
          w_nextTick   = '0;
          w_nextColumn = COL_FIRST;
        end else if (r_tick == TICK_MAX) begin
          w_nextTick = '0;
          if (r_column == COL_LAST) begin
            w_nextColumn = COL_FIRST;
            w_frameEnd   = 1'b1;
            w_capture    = 1'b1;
          end else begin
            w_nextColumn = r_column - 3'd1;
          end
        end else begin
          w_nextTick = r_tick + TICK_W'(1);
        end
      end
      default: begin
        w_nextState  = S_IDLE;
        w_nextTick   = '0;
        w_nextColumn = COL_FIRST;
      end
    endcase
  end

  always_comb begin
    w_nextSnap4     = w_capture ? column_4 : r_snap4;
    w_nextSnap3     = w_capture ? column_3 : r_snap3;
    w_nextSnap2     = w_capture ? column_2 : r_snap2;
    w_nextSnap1     = w_capture ? column_1 : r_snap1;
    w_nextSnap0     = w_capture ? column_0 : r_snap0;
    w_nextSnapState = w_capture ? state    : r_snapState;
  end

  // Blink phase for the frame that starts after the current edge. A fresh
  // LOAD, a new frame that is not in error, or the first frame of an error
  // run always starts "on" with a cleared count. Only a frame that is
  // continuing an error run advances the count and may toggle the phase.
  always_comb begin
    w_nextBlinkCnt = r_blinkCnt;
    w_nextPhaseOn  = r_phaseOn;
    if (r_state == S_LOAD) begin
      w_nextBlinkCnt = '0;
      w_nextPhaseOn  = 1'b1;
    end else if (w_frameEnd) begin
      if ((state != STATE_ERROR) || (r_snapState != STATE_ERROR)) begin
        w_nextBlinkCnt = '0;
        w_nextPhaseOn  = 1'b1;
      end else if (r_blinkCnt == BLINK_MAX) begin
        w_nextBlinkCnt = '0;
        w_nextPhaseOn  = ~r_phaseOn;
      end else begin
        w_nextBlinkCnt = r_blinkCnt + BLINK_W'(1);
      end
    end else if (r_snapState != STATE_ERROR) begin
      w_nextBlinkCnt = '0;
      w_nextPhaseOn  = 1'b1;
    end
  end

  // The outputs are decoded from next-state values and then registered.
  // Every output pin therefore comes straight from a flop, and the outputs
  // still line up with the FSM cycle they describe.
  always_comb begin
    w_nextPattern = w_nextSnap4;
    w_nextOneHot  = 5'b00000;
    case (w_nextColumn)
      3'd4: begin
        w_nextPattern = w_nextSnap4;
        w_nextOneHot  = 5'b10000;
      end
      3'd3: begin
        w_nextPattern = w_nextSnap3;
        w_nextOneHot  = 5'b01000;
      end
      3'd2: begin
        w_nextPattern = w_nextSnap2;
        w_nextOneHot  = 5'b00100;
      end
      3'd1: begin
        w_nextPattern = w_nextSnap1;
        w_nextOneHot  = 5'b00010;
      end
      3'd0: begin
        w_nextPattern = w_nextSnap0;
        w_nextOneHot  = 5'b00001;
      end
      default: begin
        w_nextPattern = 7'h00;
        w_nextOneHot  = 5'b00000;
      end
    endcase
  end

  always_comb begin
    w_nextVisible      = (w_nextState == S_SCAN) && (w_nextTick >= TICK_BLANK) && w_nextPhaseOn;
    w_nextColumnEnable = w_nextVisible ? w_nextOneHot : 5'b00000;
    w_nextRowN         = w_nextVisible ? ~w_nextPattern : 7'h7F;
    w_nextFrameDone    = (w_nextState == S_SCAN) && (w_nextColumn == COL_LAST) && (w_nextTick == TICK_MAX);
    w_nextScanning     = (w_nextState == S_SCAN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_tick         <= '0;
      r_column       <= COL_FIRST;
      r_snap4        <= 7'h00;
      r_snap3        <= 7'h00;
      r_snap2        <= 7'h00;
      r_snap1        <= 7'h00;
      r_snap0        <= 7'h00;
      r_snapState    <= 3'b000;
      r_blinkCnt     <= '0;
      r_phaseOn      <= 1'b1;
      r_columnEnable <= 5'b00000;
      r_rowN         <= 7'h7F;
      r_frameDone    <= 1'b0;
      r_scanning     <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_tick         <= w_nextTick;
      r_column       <= w_nextColumn;
      r_snap4        <= w_nextSnap4;
      r_snap3        <= w_nextSnap3;
      r_snap2        <= w_nextSnap2;
      r_snap1        <= w_nextSnap1;
      r_snap0        <= w_nextSnap0;
      r_snapState    <= w_nextSnapState;
      r_blinkCnt     <= w_nextBlinkCnt;
      r_phaseOn      <= w_nextPhaseOn;
      r_columnEnable <= w_nextColumnEnable;
      r_rowN         <= w_nextRowN;
      r_frameDone    <= w_nextFrameDone;
      r_scanning     <= w_nextScanning;
    end
  end

  assign column_enable = r_columnEnable;
  assign row_n         = r_rowN;
  assign frame_done    = r_frameDone;
  assign scanning      = r_scanning;

endmodule

// File: doc/matrix_column_scanner.md
# matrix_column_scanner

Time-multiplexing scan controller for the 5×7 LED status matrix. It takes the five 7-bit column patterns and the 3-bit display state from the image selector, snapshots them once per frame, and drives one column at a time with row data. A short blanking interval separates columns to suppress ghosting. When the display state is `error`, the whole image blinks at a frame-counted rate.

## Interface
- `DWELL_CYCLES`, default 50000: clock cycles per column slot; ≥2.
- `BLANK_CYCLES`, default 500: leading cycles of each slot with all outputs off; 0 ≤ BLANK_CYCLES < DWELL_CYCLES.
- `BLINK_FRAMES`, default 100: frames per blink half-period; ≥1.
- `clock`  in  1  system clock; every flop is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low blanks the matrix.
- `column_4` … `column_0`  in  7 each  pattern per column; bit=1 means LED lit.
- `state`  in  3  display state code; 3'b010 = error.
- `column_enable`  out  5  one-hot, active-high column drive; bit i drives column_i.
- `row_n`  out  7  active-low row drive; row_n[j] = ~pattern[j] while a column is shown, otherwise 1.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.
- `scanning`  out  1  high while in SCAN.

## Operation
- FSM states:
  - IDLE (reset state).
  - LOAD: one cycle; captures snapshot of the five columns and `state`; sets column=4, tick=0.
  - SCAN.
- Transitions:
  - IDLE→LOAD when `enable`=1.
  - LOAD→SCAN unconditionally.
  - SCAN→IDLE when `enable`=0. This is checked every cycle, including mid-slot. The next enable restarts via LOAD at column 4.
- In SCAN, tick counts 0..DWELL_CYCLES-1, width $clog2(DWELL_CYCLES).
  - At tick=DWELL_CYCLES-1, tick returns to 0 and column advances 4→3→2→1→0→4.
- Frame = five slots = 5·DWELL_CYCLES cycles.
  - On the last cycle of a frame (column 0, tick max), `frame_done`=1.
  - At that same edge, the snapshot recaptures the inputs. The next frame uses these new values, with no LOAD detour, so frame length stays fixed.
- Inputs are used only through the snapshot. Input changes mid-frame never alter the current frame.
- Column is visible when all of the following hold:
  - state=SCAN;
  - tick ≥ BLANK_CYCLES;
  - blink phase is on.
- When visible:
  - column_enable = one-hot(column);
  - row_n = ~snapshot_column.
- When not visible: column_enable=0 and row_n=7'h7F.
- Blink logic:
  - If snapshot state ≠ 3'b010: blink counter=0 and phase=on.
  - If snapshot state = 3'b010: the blink counter increments at each frame end. On reaching BLINK_FRAMES-1 it wraps to 0 and phase toggles.
  - Phase is on for the first error frame after entering error.
  - Leaving error forces phase on from the next frame.
- frame_done and the blink update happen on the same edge. The blink phase applies to the frame that starts after that edge.
- Out-of-range state codes (3'b101–3'b111) are displayed as given. No blink.

## Timing
- Reset values:
  - column_enable=5'b00000, row_n=7'h7F, frame_done=0, scanning=0;
  - FSM=IDLE; tick=0, column=4;
  - snapshot=all zeros; blink counter=0, phase=on.
- Outputs come straight from flops or from a glitch-free decode of flops. No combinational path from any input to any output.
- Latency, with the cycle where `enable` is first sampled high as E:
  - LOAD in E+1;
  - scanning=1 and first SCAN cycle (column 4, tick 0) in E+2;
  - column_enable=5'b10000 first asserted in E+2+BLANK_CYCLES.
- Disable: `enable` sampled low at edge k. From the following cycle: all outputs blank, scanning=0, frame_done=0.
- Reset may assert at any time. Outputs reach reset values immediately (asynchronous). Deassertion is synchronous to `clock` by the upstream reset synchronizer.
- BLANK_CYCLES=0: no blanking; adjacent columns switch on the same edge.

## Test plan
- Reset/idle (DWELL=4, BLANK=1): reset_n=0, then release with enable=0 → outputs hold 00000/7F/0/0 for 20 cycles.
- Scan order (DWELL=4, BLANK=1): column_4=7'b1111011, others distinct; enable=1 → after LOAD, column_enable sequence per slot is 1 blank cycle then 3 cycles of:
  - 10000 with row_n=7'b0000100;
  - then 01000, 00100, 00010, 00001, repeating.
- Frame boundary: change column_2 mid-frame → current frame unchanged, new value shown from the next frame. frame_done pulses exactly once every 20 cycles.
- Blink (BLINK_FRAMES=2): state=3'b010 → frames 1–2 visible, frames 3–4 fully blank, frames 5–6 visible. Switch to state=3'b001 → visible from the next frame.
- Disable mid-slot: enable=0 at column 3, tick 2 → next cycle blank, scanning=0. Re-enable → LOAD, restart at column 4, tick 0.
- Async reset mid-scan: reset_n low between edges → outputs at reset values before the next edge. After release with enable=1, latency to first column is BLANK_CYCLES+2.
